chdr_channel_mux: RTL
=====================

# chdr_channel_mux

Merges `NUM_PORTS` CHDR packet streams, one per channel, into a single CHDR stream. Each packet is tagged with its source channel number in the header VC field, so `chdr_channel_demux` can route it back out at the far end. Arbitration is round-robin at packet granularity, and packets are never interleaved. The block sits between per-channel NoC-block logic and a shared CHDR port.

## Interface

Parameters:
- `NUM_PORTS`, 2: number of input channels; range 1–64.
- `CHDR_W`, 64: CHDR bus width; one of 64, 128, 256, 512.
- `CHANNEL_OFFSET`, 0: channel number assigned to input port 0. `CHANNEL_OFFSET + NUM_PORTS` must be ≤ 64; an illegal value is an elaboration error.

Ports:
- `rfnoc_chdr_clk`  in  1  sole clock.
- `rfnoc_chdr_rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  `NUM_PORTS*CHDR_W`  input data; port i occupies bits [i*CHDR_W +: CHDR_W].
- `s_axis_tlast`  in  `NUM_PORTS`  input end-of-packet, one bit per port.
- `s_axis_tvalid`  in  `NUM_PORTS`  input valid, one bit per port.
- `s_axis_tready`  out  `NUM_PORTS`  input ready, one bit per port.
- `m_axis_tdata`  out  `CHDR_W`  merged output data.
- `m_axis_tlast`  out  1  output end-of-packet.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.

## Operation

- **Header beat:** the first beat of each packet. The CHDR header is in bits [63:0] and VC is bits [63:58].
- **VC rewrite:** on every header beat, VC is replaced with 6-bit (granted port + `CHANNEL_OFFSET`). All other bits of every beat pass unmodified.
- **State IDLE:**
  - All `s_axis_tready` are 0.
  - If any `s_axis_tvalid` is set, grant the first requesting port at or after `rr_ptr`, searching upward with wrap, then go to PKT.
- **State PKT:**
  - Only the granted port's `tready` follows the output stage's ready; all other ports see `tready` = 0.
  - A beat handshaken with `tlast` = 1 sets `rr_ptr` to granted+1 (mod `NUM_PORTS`, wrapping `NUM_PORTS`-1 to 0) and returns to IDLE.
- **Grant stability:** the grant never changes mid-packet. A `tvalid` drop on the granted port stalls the output; no other port is serviced meanwhile.
- **Single-port case:** with `NUM_PORTS` = 1, the rewrite still applies and the only grant is port 0.
- **Output stage:** a 2-entry pipeline register (flop2-style) drives `m_axis_*` and supplies the internal ready.
  - Internal ready is 1 while the stage holds fewer than 2 beats.
  - Ready does not depend combinationally on `m_axis_tready`.
- **Packet integrity:** no beat is dropped or duplicated; each output packet is a contiguous copy of one input packet.
- **Reset:**
  - State goes to IDLE, `rr_ptr` to 0, the output stage empties, and all `s_axis_tready` = 0.
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - Reset mid-packet discards the partial packet. Upstream must also be reset, so the next accepted beat is treated as a header.

## Timing

- **Arbitration:** one cycle in IDLE. `s_axis_tready` of the granted port rises in the cycle after the one in which IDLE sees `tvalid`.
- **Latency:** a beat accepted on `s_axis` in cycle N appears on `m_axis` in cycle N+1.
- **First-beat latency from idle:** with `m_axis_tready` = 1, `tvalid` at cycle 0 yields the header on `m_axis` at cycle 2.
- **Throughput:** one beat per cycle within a packet. Each packet boundary costs exactly one idle input cycle (the IDLE state), so throughput is L/(L+1) for L-beat packets.
- **Backpressure:** with `m_axis_tready` held at 0, at most 2 beats are absorbed, then the granted `s_axis_tready` falls.
  - `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` hold stable while `m_axis_tvalid` = 1 and `m_axis_tready` = 0.
- **Simultaneous tlast and new request:** `rr_ptr` updates in the same cycle as the tlast handshake, and the next grant uses the updated pointer.

## Test plan

- **Single packet:** `NUM_PORTS`=4, `CHANNEL_OFFSET`=2; port 1 sends a 3-beat packet with VC=0 → one 3-beat output packet with VC=3. All other bits are identical, and the header appears 2 cycles after `tvalid`.
- **Round-robin order:** all 4 ports continuously request 2-beat packets → output VC order 2,3,4,5,2,3,… with no interleaving and one bubble between packets.
- **Random stall, random backpressure:** random `tvalid` gaps on inputs and random `m_axis_tready` (50%), 1000 packets of 1–64 beats → per-channel output order and content match the scoreboard, with no loss or duplication. The same scenario passes at `CHDR_W`=128 and 512.
- **Full backpressure:** `m_axis_tready`=0 for 10 cycles mid-packet → exactly 2 beats are buffered, input `tready`=0 afterward, and output holds stable. On release, the stream resumes at 1 beat/cycle.
- **Reset mid-packet:** reset during beat 3 of a 10-beat packet → next cycle `m_axis_tvalid`=0 and all `tready`=0. A packet from port 3 after reset gets the correct VC rewrite on its first beat, and the arbiter restarts at port 0.
- **Single port:** `NUM_PORTS`=1, `CHANNEL_OFFSET`=0, back-to-back 1-beat packets → every beat is a header with VC=0 and output rate is 1 beat per 2 cycles.

Source files
------------

// File: rtl/chdr_channel_mux.sv
// Merges NUM_PORTS CHDR streams into one, round-robin per packet, tagging each header's
// VC field with the source channel so a downstream demux can route packets back out.
module chdr_channel_mux #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned CHDR_W         = 64,
  parameter int unsigned CHANNEL_OFFSET = 0
) (
  input  logic                          rfnoc_chdr_clk,
  input  logic                          rfnoc_chdr_rst,
  input  logic [NUM_PORTS*CHDR_W-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  output logic [CHDR_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 1 || CHANNEL_OFFSET + NUM_PORTS > 64) begin : g_bad_ports
    $error("chdr_channel_mux: CHANNEL_OFFSET + NUM_PORTS must be <= 64");
  end
  if (CHDR_W != 64 && CHDR_W != 128 && CHDR_W != 256 && CHDR_W != 512) begin : g_bad_width
    $error("chdr_channel_mux: CHDR_W must be 64, 128, 256 or 512");
  end

  typedef enum logic {StIdle, StPkt} state_e;

  state_e            r_state;
  logic [PW-1:0]     r_grant;
  logic [PW-1:0]     r_rr_ptr;
  logic              r_sop;
  logic [CHDR_W-1:0] r_data0, r_data1;
  logic              r_last0, r_last1;
  logic [1:0]        r_count;

  logic              w_hi_found, w_lo_found, w_req_found;
  logic [PW-1:0]     w_hi_port, w_lo_port, w_req_port;
  logic [CHDR_W-1:0] w_sel_data, w_in_data;
  logic              w_sel_last, w_sel_valid;
  logic              w_in_ready, w_push, w_pop;
  logic [5:0]        w_vc;

  // Requesters at/above rr_ptr win over those below it; descending scan keeps the lowest.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_port  = '0;
    w_lo_port  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        if (PW'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_port  = PW'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_port  = PW'(i);
        end
      end
    end
    w_req_found = w_hi_found | w_lo_found;
    w_req_port  = w_hi_found ? w_hi_port : w_lo_port;
  end

  always_comb begin
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant == PW'(i)) begin
        w_sel_data  = s_axis_tdata[i*CHDR_W +: CHDR_W];
        w_sel_last  = s_axis_tlast[i];
        w_sel_valid = s_axis_tvalid[i];
      end
    end
    w_vc      = 6'(r_grant) + 6'(CHANNEL_OFFSET);
    w_in_data = w_sel_data;
    if (r_sop) begin
      w_in_data[63:58] = w_vc;
    end
  end

  assign w_in_ready = (r_count != 2'd2);
  assign w_push     = (r_state == StPkt) && w_sel_valid && w_in_ready;
  assign w_pop      = (r_count != 2'd0) && m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_axis_tready[i] = (r_state == StPkt) && (r_grant == PW'(i)) && w_in_ready;
    end
  end

  always_ff @(posedge rfnoc_chdr_clk) begin
    if (rfnoc_chdr_rst) begin
      r_state  <= StIdle;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_sop    <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req_found) begin
            r_grant <= w_req_port;
            r_state <= StPkt;
          end
        end
        default: begin
          if (w_push) begin
            r_sop <= w_sel_last;
            if (w_sel_last) begin
              r_rr_ptr <= (r_grant == PW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
              r_state  <= StIdle;
            end
          end
        end
      endcase
    end
  end

  // Two-entry output stage: entry 0 drives m_axis, entry 1 absorbs one beat of backpressure.
  always_ff @(posedge rfnoc_chdr_clk) begin
    if (rfnoc_chdr_rst) begin
      r_count <= 2'd0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_data0 <= w_in_data;
            r_last0 <= w_sel_last;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_data0 <= w_in_data;
            r_last0 <= w_sel_last;
          end else if (w_push) begin
            r_data1 <= w_in_data;
            r_last1 <= w_sel_last;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign m_axis_tvalid = (r_count != 2'd0);
  assign m_axis_tdata  = r_data0;
  assign m_axis_tlast  = r_last0;

endmodule
